// File: rtl/y86_seq_controller_if.sv
// y86_seq_controller_if: data-memory request/acknowledge bus between the SEQ controller and data memory
interface y86_seq_controller_if;
  logic        mem_req;
  logic        mem_ack;
  logic        mem_err;
  logic [63:0] valM;
  modport master (output mem_req, input mem_ack, mem_err, valM);
  modport slave  (input mem_req, output mem_ack, mem_err, valM);
endinterface

// File: rtl/y86_seq_controller.sv
// y86_seq_controller: one-stage-per-cycle Y86-64 SEQ sequencer owning pc, status and retire/cycle counters
module y86_seq_controller #(
  parameter logic [63:0] RESET_PC = 64'd0,
  parameter logic [63:0] PC_LIMIT = 64'd128
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [3:0]                  icode,
  input  logic                        halt,
  input  logic                        invalid_instr,
  input  logic                        dmem,
  input  logic                        cnd,
  input  logic [63:0]                 valC,
  input  logic [63:0]                 valP,
  y86_seq_controller_if.master        bus,
  output logic [63:0]                 pc,
  output logic                        en_f,
  output logic                        en_d,
  output logic                        en_e,
  output logic                        en_m,
  output logic                        en_w,
  output logic [2:0]                  stat,
  output logic [31:0]                 cycle_count,
  output logic [31:0]                 instr_count
);
  localparam logic [2:0] AOK = 3'd1, HLT = 3'd2, ADR = 3'd3, INS = 3'd4;
  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_PCUPD, S_HALTED, S_FAULT
  } state_t;
  state_t      state;
  logic [3:0]  icode_q;
  logic        cnd_q;
  logic        mem_req_q;
  logic [63:0] valm_q;
  logic        is_mem;
  logic [63:0] next_pc;
  assign is_mem  = icode_q inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
  assign next_pc = ((icode_q == 4'h7 && cnd_q) || icode_q == 4'h8) ? valC :
                   icode_q == 4'h9 ? valm_q : valP;
  assign en_f = state == S_FETCH;
  assign en_d = state == S_DECODE;
  assign en_e = state == S_EXECUTE;
  assign en_m = state == S_MEMORY;
  assign en_w = state == S_WRITEBACK;
  assign bus.mem_req = mem_req_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      stat        <= AOK;
      cycle_count <= '0;
      instr_count <= '0;
      mem_req_q   <= 1'b0;
      cnd_q       <= 1'b0;
      icode_q     <= '0;
      valm_q      <= '0;
    end else begin
      if (state != S_HALTED && state != S_FAULT) cycle_count <= cycle_count + 32'd1;
      case (state)
        S_FETCH: begin
          icode_q <= icode;
          if (pc > PC_LIMIT || dmem) begin
            stat  <= ADR;
            state <= S_FAULT;
          end else if (invalid_instr) begin
            stat  <= INS;
            state <= S_FAULT;
          end else if (halt) begin
            stat  <= HLT;
            state <= S_HALTED;
          end else state <= S_DECODE;
        end
        S_DECODE: state <= S_EXECUTE;
        S_EXECUTE: begin
          cnd_q     <= cnd;
          mem_req_q <= is_mem;
          state     <= S_MEMORY;
        end
        S_MEMORY: begin
          if (!mem_req_q) state <= S_WRITEBACK;
          else if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            valm_q    <= bus.valM;
            stat      <= bus.mem_err ? ADR : stat;
            state     <= bus.mem_err ? S_FAULT : S_WRITEBACK;
          end
        end
        S_WRITEBACK: state <= S_PCUPD;
        S_PCUPD: begin
          pc          <= next_pc;
          instr_count <= instr_count + 32'd1;
          state       <= S_FETCH;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_y86_seq_controller.sv
// tb_y86_seq_controller: directed and randomized checks of the SEQ controller against an instruction-level model
module tb_y86_seq_controller;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  icode = '0;
  logic        halt = 1'b0, invalid_instr = 1'b0, dmem = 1'b0, cnd = 1'b0;
  logic [63:0] valC = '0, valP = '0;
  logic [63:0] pc;
  logic        en_f, en_d, en_e, en_m, en_w;
  logic [2:0]  stat;
  logic [31:0] cycle_count, instr_count;
  y86_seq_controller_if bus();
  y86_seq_controller dut (
    .clk(clk), .rst_n(rst_n), .icode(icode), .halt(halt), .invalid_instr(invalid_instr),
    .dmem(dmem), .cnd(cnd), .valC(valC), .valP(valP), .bus(bus), .pc(pc),
    .en_f(en_f), .en_d(en_d), .en_e(en_e), .en_m(en_m), .en_w(en_w),
    .stat(stat), .cycle_count(cycle_count), .instr_count(instr_count)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_pass = 0;
  logic [63:0] exp_pc;
  logic [2:0]  exp_stat;
  logic [31:0] exp_cyc, exp_ins;
  int          exp_lat, exp_req;
  int          obs_cyc, obs_req;
  // Instruction-level model: one call per instruction, from the documented latency and next-PC rules
  function automatic void model_step(input logic [3:0] ic, input logic [63:0] vc, vp, vm,
                                     input bit c, input int nw, input bit er, h, inv, dm);
    bit is_m = ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    if (exp_pc > 64'd128 || dm) begin exp_stat = 3'd3; exp_lat = 1; exp_req = 0; end
    else if (inv) begin exp_stat = 3'd4; exp_lat = 1; exp_req = 0; end
    else if (h) begin exp_stat = 3'd2; exp_lat = 1; exp_req = 0; end
    else if (is_m && er) begin exp_stat = 3'd3; exp_lat = 4 + nw; exp_req = nw + 1; end
    else begin
      exp_lat = is_m ? 6 + nw : 6;
      exp_req = is_m ? nw + 1 : 0;
      exp_pc  = ((ic == 4'h7 && c) || ic == 4'h8) ? vc : ic == 4'h9 ? vm : vp;
      exp_ins = exp_ins + 32'd1;
    end
    exp_cyc = exp_cyc + 32'(exp_lat);
  endfunction
  function automatic void model_reset();
    exp_pc = '0; exp_stat = 3'd1; exp_cyc = '0; exp_ins = '0;
  endfunction
  task automatic do_reset();
    rst_n = 1'b0; bus.mem_ack = 1'b0; bus.mem_err = 1'b0; bus.valM = '0;
    halt = 1'b0; invalid_instr = 1'b0; dmem = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask
  // Drives one instruction from a FETCH negedge until the next FETCH or a terminal status
  task automatic run_instr(input logic [3:0] ic, input logic [63:0] vc, vp, vm, input bit c,
                           input int nw, input bit er, h, inv, dm, output int cyc, output int req);
    bit is_m = ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    int k = 0;
    cyc = 0; req = 0;
    icode = ic; valC = vc; valP = vp; halt = h; invalid_instr = inv; dmem = dm;
    do begin
      cnd = en_e ? c : 1'($urandom);
      if (bus.mem_req) begin
        req++; k++;
        bus.mem_ack = (k == nw + 1);
        bus.mem_err = bus.mem_ack ? er : 1'($urandom);
        bus.valM    = bus.mem_ack ? vm : {$urandom, $urandom};
      end else begin
        bus.mem_ack = is_m ? 1'b0 : 1'($urandom);
        bus.mem_err = 1'($urandom);
        bus.valM    = {$urandom, $urandom};
      end
      @(posedge clk); cyc++;
      @(negedge clk);
      halt = 1'b0; invalid_instr = 1'b0; dmem = 1'b0;
    end while (!en_f && stat == 3'd1 && cyc < 40);
    bus.mem_ack = 1'b0; bus.mem_err = 1'b0;
  endtask
  task automatic idle_random(input int n);
    repeat (n) begin
      icode = 4'($urandom); halt = 1'($urandom); invalid_instr = 1'($urandom); dmem = 1'($urandom);
      cnd = 1'($urandom); bus.mem_ack = 1'($urandom); bus.mem_err = 1'($urandom);
      bus.valM = {$urandom, $urandom}; valC = {$urandom, $urandom}; valP = {$urandom, $urandom};
      @(posedge clk); @(negedge clk);
    end
  endtask
  task automatic test_reset();
    rst_n = 1'b0; bus.mem_ack = 1'b0; bus.mem_err = 1'b0; bus.valM = '0;
    #23;
    n_chk++; if (en_f !== 1'b1 || {en_d, en_e, en_m, en_w} !== 4'b0) $display("FAIL reset_en: got %b%b%b%b%b want 10000", en_f, en_d, en_e, en_m, en_w); else n_pass++;
    n_chk++; if (pc !== 64'd0 || stat !== 3'd1) $display("FAIL reset_pc_stat: got pc=%h stat=%0d want 0/1", pc, stat); else n_pass++;
    n_chk++; if (cycle_count !== 32'd0 || instr_count !== 32'd0 || bus.mem_req !== 1'b0) $display("FAIL reset_cnt: got cyc=%0d ins=%0d req=%b want 0/0/0", cycle_count, instr_count, bus.mem_req); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask
  task automatic test_straight_line();
    do_reset();
    run_instr(4'h6, 64'h0, 64'd2, 64'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, obs_cyc, obs_req);
    model_step(4'h6, 64'h0, 64'd2, 64'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_chk++; if (pc !== exp_pc || obs_cyc != exp_lat) $display("FAIL line_1: got pc=%h lat=%0d want %h/%0d", pc, obs_cyc, exp_pc, exp_lat); else n_pass++;
    run_instr(4'h2, 64'h0, 64'd4, 64'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, obs_cyc, obs_req);
    model_step(4'h2, 64'h0, 64'd4, 64'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_chk++; if (pc !== exp_pc || obs_cyc != exp_lat) $display("FAIL line_2: got pc=%h lat=%0d want %h/%0d", pc, obs_cyc, exp_pc, exp_lat); else n_pass++;
    n_chk++; if (instr_count !== exp_ins || cycle_count !== exp_cyc || stat !== exp_stat) $display("FAIL line_cnt: got ins=%0d cyc=%0d stat=%0d want %0d/%0d/%0d", instr_count, cycle_count, stat, exp_ins, exp_cyc, exp_stat); else n_pass++;
  endtask
  task automatic test_jump();
    run_instr(4'h7, 64'h40, 64'd9, 64'h0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, obs_cyc, obs_req);
    model_step(4'h7, 64'h40, 64'd9, 64'h0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_chk++; if (pc !== exp_pc) $display("FAIL jump_taken: got pc=%h want %h", pc, exp_pc); else n_pass++;
    run_instr(4'h7, 64'h40, 64'd9, 64'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, obs_cyc, obs_req);
    model_step(4'h7, 64'h40, 64'd9, 64'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_chk++; if (pc !== exp_pc || obs_cyc != exp_lat) $display("FAIL jump_not_taken: got pc=%h lat=%0d want %h/%0d", pc, obs_cyc, exp_pc, exp_lat); else n_pass++;
  endtask
  task automatic test_mem_ret();
    run_instr(4'h9, 64'h0, 64'd11, 64'h20, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0, obs_cyc, obs_req);
    model_step(4'h9, 64'h0, 64'd11, 64'h20, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0);
    n_chk++; if (obs_req != exp_req || obs_cyc != exp_lat) $display("FAIL ret_timing: got req=%0d lat=%0d want %0d/%0d", obs_req, obs_cyc, exp_req, exp_lat); else n_pass++;
    n_chk++; if (pc !== exp_pc || instr_count !== exp_ins || cycle_count !== exp_cyc) $display("FAIL ret_state: got pc=%h ins=%0d cyc=%0d want %h/%0d/%0d", pc, instr_count, cycle_count, exp_pc, exp_ins, exp_cyc); else n_pass++;
  endtask
  task automatic test_random();
    logic [3:0] ic; logic [63:0] vc, vp, vm; bit c; int nw;
    for (int i = 0; i < 30; i++) begin
      ic = 4'($urandom_range(1, 11)); c = 1'($urandom); nw = $urandom_range(0, 3);
      vc = 64'($urandom_range(0, 128)); vp = 64'($urandom_range(0, 128)); vm = 64'($urandom_range(0, 128));
      run_instr(ic, vc, vp, vm, c, nw, 1'b0, 1'b0, 1'b0, 1'b0, obs_cyc, obs_req);
      model_step(ic, vc, vp, vm, c, nw, 1'b0, 1'b0, 1'b0, 1'b0);
      n_chk++; if (pc !== exp_pc || obs_cyc != exp_lat || obs_req != exp_req) $display("FAIL rand_%0d icode=%h: got pc=%h lat=%0d req=%0d want %h/%0d/%0d", i, ic, pc, obs_cyc, obs_req, exp_pc, exp_lat, exp_req); else n_pass++;
      n_chk++; if (cycle_count !== exp_cyc || instr_count !== exp_ins || stat !== exp_stat) $display("FAIL rand_cnt_%0d: got cyc=%0d ins=%0d stat=%0d want %0d/%0d/%0d", i, cycle_count, instr_count, stat, exp_cyc, exp_ins, exp_stat); else n_pass++;
    end
  endtask
  task automatic test_counter_wrap();
    do_reset();
    icode = 4'h1; valP = 64'd8;
    force dut.cycle_count = 32'hFFFF_FFFF;
    #1 release dut.cycle_count;
    exp_cyc = 32'hFFFF_FFFF;
    model_step(4'h1, 64'h0, 64'd8, 64'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); @(negedge clk);
    n_chk++; if (cycle_count !== 32'd0) $display("FAIL wrap_zero: got %h want 00000000", cycle_count); else n_pass++;
    repeat (5) begin @(posedge clk); @(negedge clk); end
    n_chk++; if (en_f !== 1'b1 || pc !== exp_pc || cycle_count !== exp_cyc) $display("FAIL wrap_run: got en_f=%b pc=%h cyc=%0d want 1/%h/%0d", en_f, pc, cycle_count, exp_pc, exp_cyc); else n_pass++;
  endtask
  task automatic test_fault_adr();
    do_reset();
    run_instr(4'h8, 64'd130, 64'd9, 64'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, obs_cyc, obs_req);
    model_step(4'h8, 64'd130, 64'd9, 64'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_instr(4'h1, 64'h0, 64'd132, 64'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, obs_cyc, obs_req);
    model_step(4'h1, 64'h0, 64'd132, 64'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_chk++; if (stat !== exp_stat || pc !== exp_pc || obs_cyc != exp_lat) $display("FAIL adr_fault: got stat=%0d pc=%h lat=%0d want %0d/%h/%0d", stat, pc, obs_cyc, exp_stat, exp_pc, exp_lat); else n_pass++;
    idle_random(10);
    n_chk++; if (cycle_count !== exp_cyc || instr_count !== exp_ins || pc !== exp_pc || stat !== exp_stat) $display("FAIL adr_freeze: got cyc=%0d ins=%0d pc=%h stat=%0d want %0d/%0d/%h/%0d", cycle_count, instr_count, pc, stat, exp_cyc, exp_ins, exp_pc, exp_stat); else n_pass++;
    n_chk++; if ({en_f, en_d, en_e, en_m, en_w} !== 5'b0) $display("FAIL adr_enables: got %b want 00000", {en_f, en_d, en_e, en_m, en_w}); else n_pass++;
    do_reset();
    run_instr(4'h6, 64'h0, 64'd2, 64'h0, 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b1, obs_cyc, obs_req);
    model_step(4'h6, 64'h0, 64'd2, 64'h0, 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
    n_chk++; if (stat !== exp_stat || cycle_count !== exp_cyc) $display("FAIL dmem_fault: got stat=%0d cyc=%0d want %0d/%0d", stat, cycle_count, exp_stat, exp_cyc); else n_pass++;
  endtask
  task automatic test_fault_ins();
    do_reset();
    run_instr(4'hF, 64'h0, 64'd2, 64'h0, 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0, obs_cyc, obs_req);
    model_step(4'hF, 64'h0, 64'd2, 64'h0, 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    n_chk++; if (stat !== exp_stat || pc !== exp_pc) $display("FAIL ins_fault: got stat=%0d pc=%h want %0d/%h", stat, pc, exp_stat, exp_pc); else n_pass++;
    idle_random(10);
    n_chk++; if (cycle_count !== exp_cyc || instr_count !== exp_ins || stat !== exp_stat) $display("FAIL ins_freeze: got cyc=%0d ins=%0d stat=%0d want %0d/%0d/%0d", cycle_count, instr_count, stat, exp_cyc, exp_ins, exp_stat); else n_pass++;
  endtask
  task automatic test_fault_mem();
    do_reset();
    run_instr(4'h1, 64'h0, 64'd16, 64'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, obs_cyc, obs_req);
    model_step(4'h1, 64'h0, 64'd16, 64'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_instr(4'h5, 64'h0, 64'd26, 64'h50, 1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b0, obs_cyc, obs_req);
    model_step(4'h5, 64'h0, 64'd26, 64'h50, 1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_chk++; if (stat !== exp_stat || pc !== exp_pc || obs_cyc != exp_lat) $display("FAIL mem_fault: got stat=%0d pc=%h lat=%0d want %0d/%h/%0d", stat, pc, obs_cyc, exp_stat, exp_pc, exp_lat); else n_pass++;
    n_chk++; if (bus.mem_req !== 1'b0 || en_w !== 1'b0) $display("FAIL mem_fault_wb: got req=%b en_w=%b want 0/0", bus.mem_req, en_w); else n_pass++;
    idle_random(10);
    n_chk++; if (cycle_count !== exp_cyc || instr_count !== exp_ins || pc !== exp_pc) $display("FAIL mem_freeze: got cyc=%0d ins=%0d pc=%h want %0d/%0d/%h", cycle_count, instr_count, pc, exp_cyc, exp_ins, exp_pc); else n_pass++;
  endtask
  task automatic test_halt_reset();
    do_reset();
    run_instr(4'h1, 64'h0, 64'd4, 64'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, obs_cyc, obs_req);
    model_step(4'h1, 64'h0, 64'd4, 64'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_instr(4'h0, 64'h0, 64'd5, 64'h0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, obs_cyc, obs_req);
    model_step(4'h0, 64'h0, 64'd5, 64'h0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_chk++; if (stat !== exp_stat || obs_cyc != exp_lat) $display("FAIL halt_stat: got stat=%0d lat=%0d want %0d/%0d", stat, obs_cyc, exp_stat, exp_lat); else n_pass++;
    idle_random(20);
    n_chk++; if (pc !== exp_pc || cycle_count !== exp_cyc || instr_count !== exp_ins || stat !== exp_stat) $display("FAIL halt_freeze: got pc=%h cyc=%0d ins=%0d stat=%0d want %h/%0d/%0d/%0d", pc, cycle_count, instr_count, stat, exp_pc, exp_cyc, exp_ins, exp_stat); else n_pass++;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    n_chk++; if (pc !== 64'd0 || stat !== 3'd1 || cycle_count !== 32'd0 || instr_count !== 32'd0 || en_f !== 1'b1) $display("FAIL halt_async_reset: got pc=%h stat=%0d cyc=%0d ins=%0d en_f=%b want 0/1/0/0/1", pc, stat, cycle_count, instr_count, en_f); else n_pass++;
    @(negedge clk); rst_n = 1'b1; model_reset();
  endtask
  task automatic test_reset_mid_mem();
    int n = 0;
    do_reset();
    run_instr(4'h1, 64'h0, 64'd8, 64'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, obs_cyc, obs_req);
    model_step(4'h1, 64'h0, 64'd8, 64'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    icode = 4'h4; bus.mem_ack = 1'b0;
    while (!bus.mem_req && n < 10) begin @(posedge clk); @(negedge clk); n++; end
    n_chk++; if (bus.mem_req !== 1'b1 || n != 3) $display("FAIL mid_mem_entry: got req=%b after %0d cycles want 1 after 3", bus.mem_req, n); else n_pass++;
    @(posedge clk); @(posedge clk); #2 rst_n = 1'b0;
    #1;
    n_chk++; if (bus.mem_req !== 1'b0 || pc !== 64'd0 || instr_count !== 32'd0 || cycle_count !== 32'd0 || en_f !== 1'b1) $display("FAIL mid_mem_reset: got req=%b pc=%h ins=%0d cyc=%0d en_f=%b want 0/0/0/0/1", bus.mem_req, pc, instr_count, cycle_count, en_f); else n_pass++;
    @(negedge clk); rst_n = 1'b1; model_reset();
  endtask
  initial begin
    test_reset();
    test_straight_line();
    test_jump();
    test_mem_ret();
    test_random();
    test_counter_wrap();
    test_fault_adr();
    test_fault_ins();
    test_fault_mem();
    test_halt_reset();
    test_reset_mid_mem();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
